// File: rtl/pll_drp_pkg.sv
// Shared opcodes, status codes and FSM states for
// the PLL dynamic reconfiguration controller.
package pll_drp_pkg;

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_ADDR  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_VERIFY  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_INVALID = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_W_ADDR,
    S_W_DATA,
    S_R_ADDR,
    S_R_OP,
    S_R_WAIT,
    S_COMPARE,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_RESP
  } drp_state_e;

  // Divider registers hold N-1 for a divide-by-N.
  function automatic logic [7:0] div_code(
    input logic [7:0] div
  );
    return div - 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for PLL lock followed by a
// filter that needs four consecutive high samples.
module pll_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic lock_async,
  output logic lock_stable
);

  logic       sync1;
  logic       sync2;
  logic [2:0] run;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      run         <= 3'd0;
      lock_stable <= 1'b0;
    end else begin
      sync1 <= lock_async;
      sync2 <= sync1;
      if (!sync2) begin
        run         <= 3'd0;
        lock_stable <= 1'b0;
      end else begin
        if (run != 3'd4) run <= run + 3'd1;
        lock_stable <= (run >= 3'd3);
      end
    end
  end

endmodule

// File: rtl/pll_dyn_reconfig.sv
// Writes a PLL divider over the MD port, verifies it,
// resets the PLL and supervises re-lock.
module pll_dyn_reconfig
  import pll_drp_pkg::*;
#(
  parameter int         NUM_CH         = 2,
  parameter logic [7:0] ADDR_ODIV_BASE = 8'h10,
  parameter logic [7:0] ADDR_MDIV      = 8'h08,
  parameter int         READ_LAT       = 2,
  parameter int         RST_CYCLES     = 16,
  parameter int         LOCK_TIMEOUT   = 100000
) (
  input  logic                         mdclk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_CH+1)-1:0]  req_sel,
  input  logic [7:0]                   req_div,
  output logic                         rsp_valid,
  output logic [1:0]                   rsp_status,
  output logic [7:0]                   rsp_rdata,
  output logic                         busy,
  output logic [1:0]                   pll_mdopc,
  output logic                         pll_mdainc,
  output logic [7:0]                   pll_mdwdi,
  input  logic [7:0]                   pll_mdrdo,
  output logic                         pll_reset,
  input  logic                         pll_lock
);

  drp_state_e                    state;
  logic [$clog2(NUM_CH+1)-1:0]   sel_q;
  logic [7:0]                    div_q;
  logic [1:0]                    status_q;
  logic [31:0]                   cnt;
  logic [7:0]                    tgt_addr;
  logic                          lock_stable;

  always_comb begin
    tgt_addr = ADDR_ODIV_BASE + 8'(sel_q);
    if (int'(sel_q) == NUM_CH) tgt_addr = ADDR_MDIV;
  end

  pll_lock_sync u_lock_sync (
    .clk         (mdclk),
    .reset       (reset),
    .clr         (state == S_PLL_RST),
    .lock_async  (pll_lock),
    .lock_stable (lock_stable)
  );

  always_ff @(posedge mdclk) begin
    if (reset) begin
      state      <= S_IDLE;
      sel_q      <= '0;
      div_q      <= 8'd0;
      status_q   <= ST_OK;
      cnt        <= 32'd0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= 8'd0;
      busy       <= 1'b0;
      pll_mdopc  <= OPC_NOP;
      pll_mdainc <= 1'b0;
      pll_mdwdi  <= 8'd0;
      pll_reset  <= 1'b0;
    end else begin
      pll_mdopc  <= OPC_NOP;
      pll_mdwdi  <= 8'd0;
      pll_mdainc <= 1'b0;
      rsp_valid  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            sel_q     <= req_sel;
            div_q     <= req_div;
            rsp_rdata <= 8'd0;
            state     <= S_CHECK;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_CHECK: begin
          if (div_q == 8'd0 || div_q > 8'd128 ||
              int'(sel_q) > NUM_CH) begin
            status_q <= ST_INVALID;
            state    <= S_RESP;
          end else begin
            pll_mdopc <= OPC_ADDR;
            pll_mdwdi <= tgt_addr;
            state     <= S_W_ADDR;
          end
        end
        S_W_ADDR: begin
          pll_mdopc <= OPC_WRITE;
          pll_mdwdi <= div_code(div_q);
          state     <= S_W_DATA;
        end
        S_W_DATA: begin
          pll_mdopc <= OPC_ADDR;
          pll_mdwdi <= tgt_addr;
          state     <= S_R_ADDR;
        end
        S_R_ADDR: begin
          pll_mdopc <= OPC_READ;
          state     <= S_R_OP;
        end
        S_R_OP: begin
          if (READ_LAT == 1) begin
            rsp_rdata <= pll_mdrdo;
            state     <= S_COMPARE;
          end else begin
            cnt   <= 32'd0;
            state <= S_R_WAIT;
          end
        end
        // Read latency counts from the cycle the op is driven.
        S_R_WAIT: begin
          if (cnt == 32'(READ_LAT - 2)) begin
            rsp_rdata <= pll_mdrdo;
            state     <= S_COMPARE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_COMPARE: begin
          if (rsp_rdata != div_code(div_q)) begin
            status_q <= ST_VERIFY;
            state    <= S_RESP;
          end else begin
            pll_reset <= 1'b1;
            cnt       <= 32'd0;
            state     <= S_PLL_RST;
          end
        end
        S_PLL_RST: begin
          if (cnt == 32'(RST_CYCLES - 1)) begin
            pll_reset <= 1'b0;
            cnt       <= 32'd0;
            state     <= S_WAIT_LOCK;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_stable) begin
            status_q <= ST_OK;
            state    <= S_RESP;
          end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
            status_q <= ST_TIMEOUT;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_RESP: begin
          rsp_valid  <= 1'b1;
          rsp_status <= status_q;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dyn_reconfig.sv
// Directed bench for pll_dyn_reconfig with a small
// MD register model and a scripted PLL lock model.
module tb_pll_dyn_reconfig;
  import pll_drp_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int RL       = 2;
  localparam int RST      = 16;
  localparam int TMO      = 1000;
  localparam int LOCK_DLY = 50;

  localparam int LAT_INV = 2;
  localparam int LAT_VFY = 5 + RL + 1;
  localparam int LAT_OK  = 6 + RL + RST + (LOCK_DLY + 1) + 2 + 4 + 1;
  localparam int LAT_TMO = 5 + RL + RST + TMO + 1;

  logic       mdclk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic [7:0] req_div;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [1:0] pll_mdopc;
  logic       pll_mdainc;
  logic [7:0] pll_mdwdi;
  logic [7:0] pll_mdrdo = 8'd0;
  logic       pll_reset;
  logic       pll_lock = 1'b0;

  pll_dyn_reconfig #(
    .NUM_CH         (NUM_CH),
    .ADDR_ODIV_BASE (8'h10),
    .ADDR_MDIV      (8'h08),
    .READ_LAT       (RL),
    .RST_CYCLES     (RST),
    .LOCK_TIMEOUT   (TMO)
  ) dut (
    .mdclk      (mdclk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_div    (req_div),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .pll_mdopc  (pll_mdopc),
    .pll_mdainc (pll_mdainc),
    .pll_mdwdi  (pll_mdwdi),
    .pll_mdrdo  (pll_mdrdo),
    .pll_reset  (pll_reset),
    .pll_lock   (pll_lock)
  );

  initial mdclk = 1'b0;
  always #5 mdclk = ~mdclk;

  logic [7:0] md_regs [256];
  logic [7:0] md_ptr    = 8'd0;
  logic [7:0] w_addr    = 8'd0;
  logic [7:0] w_data    = 8'd0;
  logic       ainc_seen = 1'b0;
  int         ops       = 0;
  int         rst_cyc   = 0;
  int         lcnt      = 0;
  logic       lock_en;
  logic       glitch_en;
  logic       rd_force;
  logic [7:0] rd_val;

  always @(posedge mdclk) begin
    if (pll_mdainc) ainc_seen <= 1'b1;
    if (pll_mdopc != OPC_NOP) ops <= ops + 1;
    if (pll_reset) rst_cyc <= rst_cyc + 1;
    if (pll_mdopc == OPC_ADDR) md_ptr <= pll_mdwdi;
    if (pll_mdopc == OPC_WRITE) begin
      md_regs[md_ptr] <= pll_mdwdi;
      w_addr          <= md_ptr;
      w_data          <= pll_mdwdi;
    end
    if (pll_mdopc == OPC_READ)
      pll_mdrdo <= rd_force ? rd_val : md_regs[md_ptr];
    if (pll_reset) begin
      lcnt     <= 0;
      pll_lock <= 1'b0;
    end else begin
      if (lcnt < 100000) lcnt <= lcnt + 1;
      pll_lock <= lock_en && lcnt >= LOCK_DLY &&
                  !(glitch_en && (lcnt == LOCK_DLY + 2 ||
                                  lcnt == LOCK_DLY + 3));
    end
  end

  int checks = 0;
  int errors = 0;
  int ops0;
  int rst0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] sel,
                        input logic [7:0] div,
                        input string tag);
    int n;
    n = 0;
    @(negedge mdclk);
    while (!req_ready && n < 20) begin
      @(negedge mdclk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_div   = div;
    @(posedge mdclk);
    #1;
    req_valid = 1'b0;
    ops0 = ops;
    rst0 = rst_cyc;
    chk({tag, "_busy"}, 32'({req_ready, busy}), 32'b01);
  endtask

  task automatic wait_rsp(input string tag,
                          input int max,
                          input int lat_exp,
                          input logic [1:0] st_exp,
                          input logic [7:0] rd_exp);
    int lat;
    lat = 0;
    for (int n = 1; n <= max; n++) begin
      @(posedge mdclk);
      #1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_status"}, 32'(rsp_status), 32'(st_exp));
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(rd_exp));
    @(posedge mdclk);
    #1;
    chk({tag, "_after"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    logic seen;
    int   n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_sel   = 2'd0;
    req_div   = 8'd0;
    lock_en   = 1'b1;
    glitch_en = 1'b0;
    rd_force  = 1'b0;
    rd_val    = 8'd0;

    repeat (3) @(posedge mdclk);
    #1;
    chk("rst_out", 32'({req_ready, rsp_valid, rsp_status,
                        rsp_rdata, busy, pll_mdopc, pll_mdainc,
                        pll_mdwdi, pll_reset}), 32'd0);
    @(negedge mdclk);
    reset = 1'b0;
    @(posedge mdclk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);

    do_req(2'd1, 8'd24, "odiv1");
    wait_rsp("odiv1", 300, LAT_OK, ST_OK, 8'd23);
    chk("odiv1_waddr", 32'(w_addr), 32'h11);
    chk("odiv1_wdata", 32'(w_data), 32'd23);
    chk("odiv1_rstw", 32'(rst_cyc - rst0), 32'(RST));
    chk("odiv1_ops", 32'(ops - ops0), 32'd4);

    do_req(2'd0, 8'd0, "div0");
    wait_rsp("div0", 20, LAT_INV, ST_INVALID, 8'd0);
    chk("div0_ops", 32'(ops - ops0), 32'd0);
    do_req(2'd0, 8'd200, "div200");
    wait_rsp("div200", 20, LAT_INV, ST_INVALID, 8'd0);
    chk("div200_ops", 32'(ops - ops0), 32'd0);
    do_req(2'd3, 8'd5, "sel3");
    wait_rsp("sel3", 20, LAT_INV, ST_INVALID, 8'd0);
    chk("sel3_ops", 32'(ops - ops0), 32'd0);

    rd_force = 1'b1;
    rd_val   = 8'h05;
    do_req(2'd0, 8'd10, "vfy");
    wait_rsp("vfy", 50, LAT_VFY, ST_VERIFY, 8'h05);
    chk("vfy_norst", 32'(rst_cyc - rst0), 32'd0);
    rd_force = 1'b0;

    lock_en = 1'b0;
    do_req(2'd1, 8'd40, "tmo");
    wait_rsp("tmo", 1300, LAT_TMO, ST_TIMEOUT, 8'd39);
    lock_en = 1'b1;

    glitch_en = 1'b1;
    do_req(2'd2, 8'd25, "mdiv");
    wait_rsp("mdiv", 300, LAT_OK + 4, ST_OK, 8'd24);
    chk("mdiv_waddr", 32'(w_addr), 32'h08);
    chk("mdiv_wdata", 32'(w_data), 32'd24);
    glitch_en = 1'b0;

    do_req(2'd0, 8'd4, "abort");
    n = 0;
    while (!pll_reset && n < 40) begin
      @(posedge mdclk);
      #1;
      n++;
    end
    chk("abort_inrst", 32'(pll_reset), 32'd1);
    repeat (3) @(posedge mdclk);
    @(negedge mdclk);
    reset = 1'b1;
    @(posedge mdclk);
    #1;
    chk("abort_drop", 32'({pll_reset, busy, rsp_valid}), 32'd0);
    @(negedge mdclk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (120) begin
      @(posedge mdclk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_norsp", 32'(seen), 32'd0);

    do_req(2'd0, 8'd4, "fresh");
    wait_rsp("fresh", 300, LAT_OK, ST_OK, 8'd3);
    chk("fresh_waddr", 32'(w_addr), 32'h10);
    chk("fresh_wdata", 32'(w_data), 32'd3);
    chk("ainc_zero", 32'(ainc_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_dyn_reconfig.md
# pll_dyn_reconfig

Run-time reconfiguration controller for the Gowin PLLA dynamic-configuration (MD) port. It accepts divider-change requests from the control fabric (command processor or register bank), writes the new divider through the PLL's MD interface, reads it back for verification, pulses PLL reset and waits for re-lock, then returns a status. It sits between the control logic and a PLL wrapper exposing `mdclk/mdopc/mdainc/mdwdi/mdrdo`. It generalises the fixed two-output PLL wrappers to any channel count, with verify and lock supervision.

## Interface
- `NUM_CH`, 2: number of output dividers addressable (1..7); `sel == NUM_CH` selects the feedback divider (MDIV).
- `ADDR_ODIV_BASE`, 8'h10: MD address of ODIV0; ODIVk at base+k.
- `ADDR_MDIV`, 8'h08: MD address of MDIV.
- `READ_LAT`, 2: cycles from read op to valid `pll_mdrdo` (1..7).
- `RST_CYCLES`, 16: PLL reset pulse width in cycles (≥1).
- `LOCK_TIMEOUT`, 100000: max cycles waiting for lock.
- `mdclk` in 1: sole clock; also drives the PLL MDCLK.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_sel` in $clog2(NUM_CH+1): divider select.
- `req_div` in 8: new divide value.
- `rsp_valid` out 1: one-cycle status pulse.
- `rsp_status` out 2: 00 ok, 01 verify mismatch, 10 lock timeout, 11 invalid request.
- `rsp_rdata` out 8: value read back.
- `busy` out 1: high in any non-IDLE state.
- `pll_mdopc` out 2, `pll_mdainc` out 1, `pll_mdwdi` out 8, `pll_mdrdo` in 8: MD port.
- `pll_reset` out 1: to PLL RESET. `pll_lock` in 1: PLL LOCK, asynchronous.

## Operation
- FSM: IDLE → CHECK → W_ADDR → W_DATA → R_ADDR → R_OP → R_WAIT → COMPARE → PLL_RST → WAIT_LOCK → RESP → IDLE.
- IDLE: `req_ready=1`; accept on `req_valid&&req_ready`, latch sel/div.
- CHECK: invalid if `req_div==0`, `req_div>128`, or `req_sel>NUM_CH` → RESP with 11, no MD traffic.
- W_ADDR: `mdopc=OPC_ADDR`, `mdwdi=` target address. W_DATA: `mdopc=OPC_WRITE`, `mdwdi=req_div-1` (hardware encodes N-1).
- R_ADDR: same address again. R_OP: `mdopc=OPC_READ`. R_WAIT: READ_LAT cycles, then capture `mdrdo` into `rsp_rdata`.
- COMPARE: mismatch → RESP 01 (PLL not reset); match → PLL_RST.
- PLL_RST: `pll_reset=1` exactly RST_CYCLES cycles.
- WAIT_LOCK: lock passes 2-flop synchroniser; success when synced lock high 4 consecutive cycles → RESP 00; counter reaching LOCK_TIMEOUT → RESP 10.
- `pll_mdainc` always 0 (single-register access); `mdopc=OPC_NOP`, `mdwdi=0` outside the active states listed.
- `reset` mid-operation: return to IDLE next edge, drop `pll_reset` immediately, no response issued, latched request discarded.

## Timing
- Reset values: `req_ready=0` during reset then 1, `rsp_valid=0`, `rsp_status=0`, `rsp_rdata=0`, `busy=0`, `pll_mdopc=OPC_NOP`, `pll_mdainc=0`, `pll_mdwdi=0`, `pll_reset=0`.
- All outputs registered.
- Invalid request: accept edge + 2 cycles → `rsp_valid`.
- Verify mismatch: accept + 5 + READ_LAT + 1 cycles to `rsp_valid`.
- Success latency: accept + 6 + READ_LAT + RST_CYCLES + lock time + 2 (sync) + 4 (filter) + 1.
- `req_ready` low from accept edge until the cycle after `rsp_valid`; requests while busy are ignored, not queued.
- Lock glitch during the 4-cycle filter restarts the filter, not the timeout.

## Structure
- Package `pll_drp_pkg`: `OPC_NOP=2'b00`, `OPC_WRITE=2'b01`, `OPC_READ=2'b10`, `OPC_ADDR=2'b11`; status codes; FSM state enum.
- Sub-module `pll_lock_sync`: 2-flop synchroniser plus 4-cycle stability filter, output `lock_stable`.

## Test plan
- NUM_CH=2, sel=1, div=24, model echoes write, lock after 50 cycles → W_DATA `mdwdi=8'd23` to addr 8'h11, `pll_reset` 16 cycles, status 00, `rsp_rdata=23`.
- div=0 and div=200 → status 11 two cycles after accept, `pll_mdopc` stays NOP.
- Model returns 8'h05 on read for div=10 → status 01, `pll_reset` never asserted.
- LOCK_TIMEOUT=1000, lock held low → status 10 exactly 1000 cycles into WAIT_LOCK.
- sel=NUM_CH, div=25 → address 8'h08, data 8'd24; lock glitches low for 2 cycles during filter → success still reported, later.
- `reset` asserted in PLL_RST → next cycle `pll_reset=0`, `busy=0`, no `rsp_valid`; fresh request then completes normally.
